// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and default sizes for the data memory and its arbiter.
package data_memory_arbiter_pkg;
  localparam int DEF_SIZE   = 32;
  localparam int DEF_LENGTH = 256;

  typedef enum logic {ARB, BURST} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;
endpackage

// File: rtl/data_memory_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module data_memory_arbiter_sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_cnt <= '0;
    else if (i_clr)                        r_cnt <= '0;
    else if (i_inc && (r_cnt != W'(MAX)))  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/data_memory_arbiter.sv
// Single-port data memory arbiter: CPU vs DMA/debug, zero-latency grant,
// DMA starvation guard and bounded locked DMA bursts.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int LENGTH    = DEF_LENGTH,
  parameter int ADDR_W    = $clog2(LENGTH),
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [SIZE-1:0]   cpu_wdata,
  output logic              cpu_gnt,
  output logic [SIZE-1:0]   cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [SIZE-1:0]   dma_wdata,
  output logic              dma_gnt,
  output logic [SIZE-1:0]   dma_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [SIZE-1:0]   mem_write_data,
  input  logic [SIZE-1:0]   mem_read_data
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e   r_state, w_nxt;
  owner_e       w_own;
  logic [SW-1:0] w_starve;
  logic [BW-1:0] w_burst;
  logic         w_cpu_gnt, w_dma_gnt;
  logic         w_starve_max, w_burst_last;

  assign w_starve_max = (w_starve == SW'(MAX_WAIT));
  // The beat seeing MAX_BURST-1 is the MAX_BURST-th granted beat.
  assign w_burst_last = (w_burst == BW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ARB;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_own = OWN_NONE;
    w_nxt = r_state;
    case (r_state)
      ARB: begin
        if (dma_req && (!cpu_req || w_starve_max)) w_own = OWN_DMA;
        else if (cpu_req)                          w_own = OWN_CPU;
        if ((w_own == OWN_DMA) && dma_lock)        w_nxt = BURST;
      end
      BURST: begin
        if (dma_req) begin
          w_own = OWN_DMA;
          if (!dma_lock || w_burst_last) w_nxt = ARB;
        end else begin
          // DMA let go mid-lock: hand this cycle to the CPU.
          w_nxt = ARB;
          if (cpu_req) w_own = OWN_CPU;
        end
      end
      default: w_nxt = ARB;
    endcase
    if (!reset_n) w_own = OWN_NONE;
  end

  assign w_cpu_gnt = (w_own == OWN_CPU);
  assign w_dma_gnt = (w_own == OWN_DMA);

  data_memory_arbiter_sat_counter #(.MAX(MAX_WAIT), .W(SW)) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (dma_req & ~w_dma_gnt),
    .i_clr   (w_dma_gnt | ~dma_req),
    .o_cnt   (w_starve)
  );

  data_memory_arbiter_sat_counter #(.MAX(MAX_BURST), .W(BW)) u_burst (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_dma_gnt & (w_nxt == BURST)),
    .i_clr   (w_nxt == ARB),
    .o_cnt   (w_burst)
  );

  assign cpu_gnt        = w_cpu_gnt;
  assign dma_gnt        = w_dma_gnt;
  assign mem_write      = (w_cpu_gnt & cpu_we) | (w_dma_gnt & dma_we);
  assign mem_read       = (w_cpu_gnt & ~cpu_we) | (w_dma_gnt & ~dma_we);
  assign mem_address    = w_dma_gnt ? dma_addr  : (w_cpu_gnt ? cpu_addr  : '0);
  assign mem_write_data = w_dma_gnt ? dma_wdata : (w_cpu_gnt ? cpu_wdata : '0);
  assign cpu_rdata      = mem_read_data;
  assign dma_rdata      = mem_read_data;
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store path and a DMA/debug port.
- Grants at most one requester per cycle and drives the memory write/read/address/data pins.
- Read data is returned in the same cycle, because memory read is combinational.
- Sequential state provides DMA starvation protection and bounded DMA burst locking.

Parameters:
- SIZE, 32, data word width.
- LENGTH, 256, number of memory locations.
- ADDR_W, $clog2(LENGTH), address width (derived; do not override).
- MAX_WAIT, 4, consecutive denied DMA cycles before DMA wins over CPU.
- MAX_BURST, 8, maximum consecutive locked DMA beats before a forced release.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU access request.
- cpu_we  input  1  CPU write (1) / read (0).
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  SIZE  CPU write data.
- cpu_gnt  output  1  CPU access performed this cycle.
- cpu_rdata  output  SIZE  CPU read data; valid when cpu_gnt & ~cpu_we.
- dma_req  input  1  DMA access request.
- dma_we  input  1  DMA write / read.
- dma_lock  input  1  DMA requests to hold the port for the next beat.
- dma_addr  input  ADDR_W  DMA address.
- dma_wdata  input  SIZE  DMA write data.
- dma_gnt  output  1  DMA access performed this cycle.
- dma_rdata  output  SIZE  DMA read data; valid when dma_gnt & ~dma_we.
- mem_write  output  1  to memory memWrite.
- mem_read  output  1  to memory memRead.
- mem_address  output  ADDR_W  to memory address.
- mem_write_data  output  SIZE  to memory writeData.
- mem_read_data  input  SIZE  from memory readData.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values:
  - state = ARB, starve_cnt = 0, burst_cnt = 0.
  - While reset_n is low, cpu_gnt, dma_gnt, mem_write and mem_read are forced to 0.
  - mem_address and mem_write_data are forced to 0 while reset_n is low.
- Grant timing:
  - Grant is combinational from the current requests plus registered state. Zero latency.
  - A request with no grant must be held by the requester and is retried every cycle.
- Memory drive:
  - Granted requester's addr/wdata go to mem_address/mem_write_data.
  - mem_write = gnt & we; mem_read = gnt & ~we.
  - With no grant, both strobes are 0 and address/data are 0.
- Read data: cpu_rdata and dma_rdata both equal mem_read_data combinationally. Each is meaningful only under its own read grant.
- FSM states: ARB, BURST.
- ARB:
  - DMA wins if dma_req & (~cpu_req | starve_cnt == MAX_WAIT). Otherwise CPU wins if cpu_req.
  - If DMA is granted with dma_lock = 1: go to BURST, burst_cnt <= 1.
- BURST:
  - DMA has absolute priority while dma_req = 1; cpu_gnt = 0.
  - Each DMA grant increments burst_cnt.
  - Return to ARB after the DMA beat on which any of these holds: dma_lock = 0, burst_cnt == MAX_BURST, or dma_req = 0.
  - dma_req = 0 in BURST: no grant that cycle, and the CPU may be granted that same cycle.
  - After a forced exit at MAX_BURST, starve_cnt is 0, so a waiting CPU wins the next cycle.
- starve_cnt:
  - Increments, saturating at MAX_WAIT, when dma_req & ~dma_gnt.
  - Clears on dma_gnt or ~dma_req.
- Simultaneous events:
  - cpu_req & dma_req in ARB with starve_cnt < MAX_WAIT: CPU wins.
  - A write and a read never issue in the same cycle.
- Reset mid-burst: immediate return to ARB with counters cleared. No memory strobe is asserted during reset.
- Widths: counters are $clog2(MAX_WAIT+1) and $clog2(MAX_BURST+1) bits. No overflow is possible because both saturate or are bounded.

Decomposition:
- Shared package holds:
  - state enum (ARB, BURST);
  - owner encoding (NONE, CPU, DMA);
  - default SIZE and LENGTH constants, shared with data_memory.
- One sub-module is natural: sat_counter, a parameterised saturating counter with inc/clr. It is instanced twice, for starve_cnt and burst_cnt.
- Everything else stays in the arbiter.

Test Plan:
- Reset: reset_n = 0 with cpu_req = dma_req = 1 -> all grants 0, mem_write = mem_read = 0. Release reset -> CPU granted next cycle.
- CPU only: write 0xDEADBEEF @0x10, then read @0x10 -> cpu_gnt = 1 both cycles. Read cycle has mem_read = 1 and cpu_rdata = 0xDEADBEEF.
- Contention: cpu_req and dma_req both held continuously, no lock, MAX_WAIT = 4 -> CPU granted 4 cycles, DMA granted on the 5th, pattern repeats.
- Burst: dma_lock = 1, dma_req held, cpu_req held, MAX_BURST = 8 -> 8 consecutive DMA grants, then one CPU grant, with dma_rdata matching preloaded values.
- Early unlock: dma_lock drops on the 3rd beat -> exit to ARB after beat 3, and the CPU is granted the next cycle.
- Reset mid-burst: assert reset_n = 0 on beat 5 -> strobes drop immediately. After release, state is ARB and the CPU wins on contention.
